divider: RTL

Iterative radix-2 restoring divider. It is the inverse companion of the combinational 64x64 multiplier in the ALU.
- Takes a 64-bit dividend and divisor and produces a 64-bit quotient and remainder, signed or unsigned.
- Computes one quotient bit per cycle, under a start/done handshake.
- Sits beside the multiplier in the ALU. The ALU control stalls on busy until done.

---
 rtl/divider.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/divider.sv
// ---------------------------------------------------------------------------
// divider
// Iterative radix-2 restoring divider, signed or unsigned, one quotient bit
// per cycle. It sits beside the combinational multiplier in the ALU, and the
// ALU control stalls on busy until done.
//
// Ports
//   clk        clock, all state changes on the rising edge
//   rst        synchronous active-high reset
//   start      request pulse, sampled only in IDLE
//   signed_op  1 = two's-complement operands, 0 = unsigned
//   a, b       dividend / divisor, sampled with start
//   quot, rem  quotient (truncated toward zero) / remainder (sign of dividend)
//   busy       high from the cycle after acceptance until done
//   done       one-cycle pulse; quot/rem/dbz/ovf valid
//   dbz, ovf   divide-by-zero / signed overflow (MIN / -1) flags
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | waiting for start; results from the last operation held
// BUSY   | one shift/trial-subtract per cycle, WIDTH iterations
// FIX    | apply result signs for signed operation
// DONE   | done pulse for one cycle, then back to IDLE
// ---------------------------------------------------------------------------
module divider #(
   parameter int WIDTH = 64
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             signed_op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] quot,
   output logic [WIDTH-1:0] rem,
   output logic             busy,
   output logic             done,
   output logic             dbz,
   output logic             ovf
);

   localparam int CW = $clog2(WIDTH) + 1;
   localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {
      S_IDLE,
      S_BUSY,
      S_FIX,
      S_DONE
   } state_t;

   state_t           r_state;
   logic [WIDTH-1:0] r_pr;      // partial remainder
   logic [WIDTH-1:0] r_dvd;     // dividend shifting out, quotient shifting in
   logic [WIDTH-1:0] r_dvs;     // divisor magnitude
   logic [CW-1:0]    r_cnt;
   logic             r_neg_a;
   logic             r_neg_b;
   logic [WIDTH-1:0] r_quot;
   logic [WIDTH-1:0] r_rem;
   logic             r_busy;
   logic             r_done;
   logic             r_dbz;
   logic             r_ovf;

   logic             w_a_neg;
   logic             w_b_neg;
   logic [WIDTH-1:0] w_a_mag;
   logic [WIDTH-1:0] w_b_mag;
   logic [WIDTH:0]   w_shift;
   logic [WIDTH:0]   w_diff;
   logic             w_fit;
   logic             w_last;
   logic [WIDTH-1:0] w_quot_fix;
   logic [WIDTH-1:0] w_rem_fix;

   assign w_a_neg = signed_op & a[WIDTH-1];
   assign w_b_neg = signed_op & b[WIDTH-1];
   // -MIN wraps to MIN, which is the correct unsigned magnitude 2^(WIDTH-1).
   assign w_a_mag = w_a_neg ? (~a + 1'b1) : a;
   assign w_b_mag = w_b_neg ? (~b + 1'b1) : b;

   // The partial remainder is always below the divisor, so the shifted value
   // is below twice the divisor; one extra bit is enough to carry the sign of
   // the trial difference.
   assign w_shift = {r_pr, r_dvd[WIDTH-1]};
   assign w_diff  = w_shift - {1'b0, r_dvs};
   assign w_fit   = ~w_diff[WIDTH];
   assign w_last  = (r_cnt == CW'(WIDTH - 1));

   assign w_quot_fix = (r_neg_a ^ r_neg_b) ? (~r_dvd + 1'b1) : r_dvd;
   assign w_rem_fix  = r_neg_a ? (~r_pr + 1'b1) : r_pr;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_pr    <= '0;
         r_dvd   <= '0;
         r_dvs   <= '0;
         r_cnt   <= '0;
         r_neg_a <= 1'b0;
         r_neg_b <= 1'b0;
         r_quot  <= '0;
         r_rem   <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_dbz   <= 1'b0;
         r_ovf   <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_done <= 1'b0;
               if (start) begin
                  r_quot <= '0;
                  r_rem  <= '0;
                  r_dbz  <= 1'b0;
                  r_ovf  <= 1'b0;
                  if (b == '0) begin
                     r_quot  <= '1;
                     r_rem   <= a;
                     r_dbz   <= 1'b1;
                     r_done  <= 1'b1;
                     r_state <= S_DONE;
                  end else if (signed_op && (a == MIN_VAL) && (b == '1)) begin
                     r_quot  <= a;
                     r_ovf   <= 1'b1;
                     r_done  <= 1'b1;
                     r_state <= S_DONE;
                  end else begin
                     r_pr    <= '0;
                     r_dvd   <= w_a_mag;
                     r_dvs   <= w_b_mag;
                     r_cnt   <= '0;
                     r_neg_a <= w_a_neg;
                     r_neg_b <= w_b_neg;
                     r_busy  <= 1'b1;
                     r_state <= S_BUSY;
                  end
               end
            end

            S_BUSY: begin
               if (w_fit) begin
                  r_pr  <= w_diff[WIDTH-1:0];
                  r_dvd <= {r_dvd[WIDTH-2:0], 1'b1};
               end else begin
                  r_pr  <= w_shift[WIDTH-1:0];
                  r_dvd <= {r_dvd[WIDTH-2:0], 1'b0};
               end
               r_cnt <= r_cnt + 1'b1;
               if (w_last) begin
                  r_state <= S_FIX;
               end
            end

            S_FIX: begin
               r_quot  <= w_quot_fix;
               r_rem   <= w_rem_fix;
               r_busy  <= 1'b0;
               r_done  <= 1'b1;
               r_state <= S_DONE;
            end

            S_DONE: begin
               r_done  <= 1'b0;
               r_state <= S_IDLE;
            end

            default: begin
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign quot = r_quot;
   assign rem  = r_rem;
   assign busy = r_busy;
   assign done = r_done;
   assign dbz  = r_dbz;
   assign ovf  = r_ovf;

endmodule
